// File: rtl/dither_readback_tx.sv
// Readback transmitter: sweeps the pixel SRAM in raster order and streams bytes to the MCU
// through a 2-entry credit-tracked output buffer, optionally packing 8 pixels per byte.
module dither_readback_tx #(
   parameter int IMAGEX           = 64,
   parameter int IMAGEY           = 64,
   parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
   parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
   parameter int RGB_SIZE         = 8,
   parameter int PACK             = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        sram_rden,
   output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
   input  logic [RGB_SIZE-1:0]         sram_rddata,
   output logic [RGB_SIZE-1:0]         mcu_data,
   output logic                        mcu_valid,
   input  logic                        mcu_ready,
   output logic                        busy,
   output logic                        done
);

   localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [IMAGE_ADDR_WIDTH-1:0] rd_ptr, last_addr;
   logic                        in_flight, flight_completes;
   logic [RGB_SIZE-1:0]         pk_shift;
   logic [2:0]                  pk_cnt;
   logic [RGB_SIZE-1:0]         head, tail;
   logic [1:0]                  occ;
   logic                        pop, push, issue, new_completes, drained;
   logic [RGB_SIZE-1:0]         push_data;
   logic [2:0]                  demand;

   assign pop           = mcu_valid && mcu_ready;
   assign new_completes = (PACK == 0) || ((32'(rd_ptr) & 32'd7) == 32'd7);
   // Slots needed once this cycle's pop retires: buffered bytes, the byte owed by the
   // in-flight read, and the byte the candidate read would produce.
   assign demand        = 3'(occ) - 3'(pop) + 3'(flight_completes) + 3'(new_completes);
   assign issue         = (state == READ) && (demand <= 3'd2);

   assign push      = in_flight && ((PACK == 0) || (pk_cnt == 3'd7));
   assign push_data = (PACK == 0) ? sram_rddata
                                  : {pk_shift[RGB_SIZE-2:0], sram_rddata[RGB_SIZE-1]};
   assign drained   = !in_flight && (pk_cnt == 3'd0) &&
                      ((occ == 2'd0) || ((occ == 2'd1) && pop));

   assign sram_rden = issue;
   assign sram_addr = issue ? rd_ptr : last_addr;
   assign mcu_valid = (occ != 2'd0);
   assign mcu_data  = head;
   assign busy      = (state == READ) || (state == DRAIN);
   assign done      = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (issue && (rd_ptr == LAST_ADDR)) state_nxt = DRAIN;
         DRAIN:   if (drained) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr           <= '0;
         last_addr        <= '0;
         in_flight        <= 1'b0;
         flight_completes <= 1'b0;
         pk_shift         <= '0;
         pk_cnt           <= 3'd0;
         head             <= '0;
         tail             <= '0;
         occ              <= 2'd0;
      end else begin
         in_flight        <= issue;
         flight_completes <= issue && new_completes;

         if ((state == IDLE) && start) begin
            rd_ptr <= '0;
         end else if (issue) begin
            last_addr <= rd_ptr;
            if (rd_ptr != LAST_ADDR) rd_ptr <= rd_ptr + 1'b1;
         end

         if ((state == IDLE) && start) begin
            pk_shift <= '0;
            pk_cnt   <= 3'd0;
         end else if ((PACK != 0) && in_flight) begin
            pk_shift <= {pk_shift[RGB_SIZE-2:0], sram_rddata[RGB_SIZE-1]};
            pk_cnt   <= pk_cnt + 3'd1;
         end

         // Head register always holds the oldest byte so mcu_data comes straight from a flop.
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= push_data;
               else             tail <= push_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dither_readback_tx.sv
// Self-checking bench for dither_readback_tx: a 4x4 unpacked and a 4x4 packed instance share
// one SRAM image; streams are compared against a reference built from the image contents.
module tb_dither_readback_tx;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst_n, mcu_ready, start0, start1;
   logic       rden0, valid0, busy0, done0;
   logic       rden1, valid1, busy1, done1;
   logic [3:0] addr0, addr1;
   logic [7:0] rdd0, rdd1, data0, data1;
   logic [7:0] mem [N];

   always #5 clk = ~clk;

   dither_readback_tx #(.IMAGEX(4), .IMAGEY(4), .PACK(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .sram_rden(rden0), .sram_addr(addr0),
      .sram_rddata(rdd0), .mcu_data(data0), .mcu_valid(valid0), .mcu_ready(mcu_ready),
      .busy(busy0), .done(done0));

   dither_readback_tx #(.IMAGEX(4), .IMAGEY(4), .PACK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sram_rden(rden1), .sram_addr(addr1),
      .sram_rddata(rdd1), .mcu_data(data1), .mcu_valid(valid1), .mcu_ready(mcu_ready),
      .busy(busy1), .done(done1));

   // One-cycle-latency SRAM model
   always @(posedge clk) begin
      if (rden0) rdd0 <= mem[addr0];
      if (rden1) rdd1 <= mem[addr1];
   end

   typedef struct {
      string name;
      bit    pack;
      int    ready_pct;
      int    restart_at;
      int    fill;
      int    nbytes;
      int    max_first;
   } vec_t;

   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int acc, iss, hits, first_valid_k, first_acc_k, last_acc_k, done_k, done_cnt, prot_err;
   int post_busy, post_done;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic fillMem(input int mode);
      for (int i = 0; i < N; i++) begin
         if (mode == 0)      mem[i] = 8'(i);
         else if (mode == 1) mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
         else                mem[i] = 8'($urandom_range(255));
      end
   endtask

   // Reference: raw pixels, or MSB-of-pixel bits packed 8 at a time, first pixel most significant
   task automatic buildModel(input bit pack);
      exp_q.delete();
      if (!pack) begin
         for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
      end else begin
         for (int b = 0; b < N / 8; b++) begin
            int v = 0;
            for (int j = 0; j < 8; j++) v = v * 2 + ((mem[8 * b + j] >= 8'd128) ? 1 : 0);
            exp_q.push_back(8'(v));
         end
      end
   endtask

   task automatic applyStimulus(input bit pack, input int ready_pct, input int restart_at);
      logic       v, rd, dn, bz, prev_stall;
      logic [7:0] d, prev_d;
      logic [3:0] ad;
      bit         restarted;
      got_q.delete();
      acc = 0; iss = 0; hits = 0; done_cnt = 0; prot_err = 0;
      first_valid_k = -1; first_acc_k = -1; last_acc_k = -1; done_k = -1;
      post_busy = -1; post_done = -1;
      prev_stall = 1'b0; prev_d = 8'd0; restarted = 1'b0;
      @(negedge clk);
      mcu_ready = ($urandom_range(99) < ready_pct);
      if (pack) start1 = 1'b1; else start0 = 1'b1;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         start0 = 1'b0;
         start1 = 1'b0;
         mcu_ready = ($urandom_range(99) < ready_pct);
         if (restart_at >= 0 && acc == restart_at && !restarted) begin
            if (pack) start1 = 1'b1; else start0 = 1'b1;
            restarted = 1'b1;
         end
         #1;
         v  = pack ? valid1 : valid0;
         d  = pack ? data1  : data0;
         rd = pack ? rden1  : rden0;
         ad = pack ? addr1  : addr0;
         dn = pack ? done1  : done0;
         bz = pack ? busy1  : busy0;
         if (done_k > 0 && k == done_k + 1) begin
            post_busy = int'(bz);
            post_done = int'(dn);
            break;
         end
         if (prev_stall && (!v || d !== prev_d)) prot_err++;
         prev_stall = v && !mcu_ready;
         prev_d     = d;
         if (v && first_valid_k < 0) first_valid_k = k;
         if (rd) begin
            if (ad !== 4'(iss)) prot_err++;
            if (!pack || (iss % 8 == 7)) hits++;
            iss++;
         end
         if (v && mcu_ready) begin
            got_q.push_back(d);
            acc++;
            if (first_acc_k < 0) first_acc_k = k;
            last_acc_k = k;
         end
         if (hits - acc > 2 || iss > N) prot_err++;
         if (dn) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
            if (bz) prot_err++;
         end
      end
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   initial begin
      vec_t vecs[7];
      int   errs, stall_err;
      vecs[0] = '{"basic",       1'b0, 100, -1, 0, 16, 3};
      vecs[1] = '{"backpress",   1'b0,  30, -1, 0, 16, 3};
      vecs[2] = '{"pack_alt",    1'b1, 100, -1, 1,  2, 10};
      vecs[3] = '{"start_busy",  1'b0, 100,  3, 0, 16, 3};
      vecs[4] = '{"rand_unpack", 1'b0,  50, -1, 2, 16, 3};
      vecs[5] = '{"rand_pack",   1'b1,  40, -1, 2,  2, 10};
      vecs[6] = '{"pack_busy",   1'b1,  70,  1, 2,  2, 10};

      rst_n = 1'b0; mcu_ready = 1'b0; start0 = 1'b0; start1 = 1'b0;
      fillMem(0);
      repeat (3) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("reset rden",  int'(rden0),  0);
      checkOutput("reset addr",  int'(addr0),  0);
      checkOutput("reset valid", int'(valid0), 0);
      checkOutput("reset data",  int'(data0),  0);
      checkOutput("reset busy",  int'(busy0),  0);
      checkOutput("reset done",  int'(done0),  0);
      start0 = 1'b0;
      rst_n  = 1'b1;

      for (int i = 0; i < 7; i++) begin
         fillMem(vecs[i].fill);
         buildModel(vecs[i].pack);
         applyStimulus(vecs[i].pack, vecs[i].ready_pct, vecs[i].restart_at);
         errs = 0;
         for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
            if (got_q[j] !== exp_q[j]) errs++;
         checkOutput($sformatf("%s byte count", vecs[i].name), got_q.size(), vecs[i].nbytes);
         checkOutput($sformatf("%s byte mismatches", vecs[i].name), errs, 0);
         checkOutput($sformatf("%s done pulses", vecs[i].name), done_cnt, 1);
         checkOutput($sformatf("%s done after last accept", vecs[i].name), done_k - last_acc_k, 1);
         checkOutput($sformatf("%s busy after done", vecs[i].name), post_busy, 0);
         checkOutput($sformatf("%s done width", vecs[i].name), post_done, 0);
         checkOutput($sformatf("%s protocol violations", vecs[i].name), prot_err, 0);
         checkOutput($sformatf("%s first valid cycle within %0d", vecs[i].name, vecs[i].max_first),
                     (first_valid_k > 0 && first_valid_k <= vecs[i].max_first) ? first_valid_k : -1,
                     first_valid_k);
         if (vecs[i].ready_pct == 100 && !vecs[i].pack)
            checkOutput($sformatf("%s burst span", vecs[i].name),
                        last_acc_k - first_acc_k, vecs[i].nbytes - 1);
      end

      // Stall at end: hold off the last two bytes while everything is already read
      fillMem(0);
      got_q.delete(); acc = 0; done_cnt = 0; stall_err = 0;
      @(negedge clk);
      mcu_ready = 1'b1;
      start0    = 1'b1;
      for (int k = 0; k < 100 && acc < 14; k++) begin
         @(negedge clk);
         start0 = 1'b0;
         mcu_ready = 1'b1;
         #1;
         if (valid0 && mcu_ready) begin got_q.push_back(data0); acc++; end
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         mcu_ready = 1'b0;
         #1;
         if (rden0 || !busy0 || done0 || !valid0 || data0 !== 8'd14 || addr0 !== 4'd15)
            stall_err++;
      end
      checkOutput("stall accepts before hold", acc, 14);
      checkOutput("stall hold violations", stall_err, 0);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         mcu_ready = 1'b1;
         #1;
         if (valid0 && mcu_ready) got_q.push_back(data0);
         if (done0) begin done_cnt++; break; end
      end
      checkOutput("stall total bytes", got_q.size(), 16);
      checkOutput("stall last byte", (got_q.size() > 0) ? int'(got_q[got_q.size() - 1]) : -1, 15);
      checkOutput("stall done pulses", done_cnt, 1);

      // Reset mid-frame after the 5th byte, with start held during reset
      fillMem(0);
      acc = 0;
      @(negedge clk);
      mcu_ready = 1'b1;
      start0    = 1'b1;
      for (int k = 0; k < 100 && acc < 5; k++) begin
         @(negedge clk);
         start0 = 1'b0;
         #1;
         if (valid0 && mcu_ready) acc++;
      end
      @(negedge clk);
      rst_n  = 1'b0;
      start0 = 1'b1;
      @(negedge clk);
      rst_n  = 1'b1;
      start0 = 1'b0;
      #1;
      checkOutput("midreset rden",  int'(rden0),  0);
      checkOutput("midreset addr",  int'(addr0),  0);
      checkOutput("midreset valid", int'(valid0), 0);
      checkOutput("midreset data",  int'(data0),  0);
      checkOutput("midreset busy",  int'(busy0),  0);
      checkOutput("midreset done",  int'(done0),  0);
      buildModel(1'b0);
      applyStimulus(1'b0, 100, -1);
      checkOutput("restart first byte", (got_q.size() > 0) ? int'(got_q[0]) : -1, int'(exp_q[0]));
      checkOutput("restart byte count", got_q.size(), 16);
      checkOutput("restart done pulses", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
